memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory.sv | 207 ++++++++++++++++++++
 tb/tb_memory.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Memory stage: issues one load/store bus access per instruction, aligns and extends
// load data, flags misaligned accesses, and registers every field handed to writeback.
module memory (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] csr_data_in,
    input  logic        branch_taken_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic        load_signed_in,
    input  logic        csr_write_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [1:0]  load_store_size_in,
    input  logic [1:0]  write_select_in,
    input  logic [4:0]  rd_address_in,
    input  logic [11:0] csr_address_in,
    input  logic [3:0]  ecause_in,
    input  logic        stall,
    input  logic        invalidate,
    output logic [31:0] mem_address,
    output logic [31:0] mem_store_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    input  logic [31:0] mem_load_data,
    output logic        mem_busy,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] csr_data_out,
    output logic [31:0] load_data_out,
    output logic        branch_taken_out,
    output logic        csr_write_out,
    output logic        mret_out,
    output logic        wfi_out,
    output logic        valid_out,
    output logic        exception_out,
    output logic [1:0]  write_select_out,
    output logic [4:0]  rd_address_out,
    output logic [11:0] csr_address_out,
    output logic [3:0]  ecause_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q;
    logic        ld_q, st_q, sgn_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q, next_pc_q, alu_q, csr_data_q, load_data_q;
    logic        branch_q, csr_write_q, mret_q, wfi_q, valid_q, exc_q;
    logic [1:0]  wsel_q;
    logic [4:0]  rd_q;
    logic [11:0] csr_addr_q;
    logic [3:0]  ecause_q;

    logic        in_access;
    logic        is_mem;
    logic        misaligned;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic sgn, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (size)
            2'd0:    return {{24{sgn & sh[7]}}, sh[7:0]};
            2'd1:    return {{16{sgn & sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    assign in_access = (state_q == ACCESS);
    assign is_mem    = load_in | store_in;

    always_comb begin
        misaligned = 1'b0;
        if (is_mem) begin
            if (load_store_size_in == 2'd1)
                misaligned = alu_data_in[0];
            else if (load_store_size_in[1])
                misaligned = (alu_data_in[1:0] != 2'b00);
        end
    end

    // Bus request is driven purely from latched state, so it stays constant until mem_ready.
    assign mem_read        = in_access & ld_q;
    assign mem_write       = in_access & st_q;
    assign mem_address     = in_access ? {alu_q[31:2], 2'b00} : 32'd0;
    assign mem_byte_enable = in_access ? byte_enable(size_q, alu_q[1:0]) : 4'b0000;
    assign mem_store_data  = store_lanes(size_q, wdata_q);
    assign mem_busy        = in_access & ~mem_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ld_q        <= 1'b0;
            st_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= 2'd0;
            wdata_q     <= 32'd0;
            pc_q        <= 32'd0;
            next_pc_q   <= 32'd0;
            alu_q       <= 32'd0;
            csr_data_q  <= 32'd0;
            load_data_q <= 32'd0;
            branch_q    <= 1'b0;
            csr_write_q <= 1'b0;
            mret_q      <= 1'b0;
            wfi_q       <= 1'b0;
            valid_q     <= 1'b0;
            exc_q       <= 1'b0;
            wsel_q      <= 2'd0;
            rd_q        <= 5'd0;
            csr_addr_q  <= 12'd0;
            ecause_q    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stall) begin
                        if (valid_in && !invalidate) begin
                            pc_q        <= pc_in;
                            next_pc_q   <= next_pc_in;
                            alu_q       <= alu_data_in;
                            csr_data_q  <= csr_data_in;
                            load_data_q <= 32'd0;
                            branch_q    <= branch_taken_in;
                            csr_write_q <= csr_write_in;
                            mret_q      <= mret_in;
                            wfi_q       <= wfi_in;
                            wsel_q      <= write_select_in;
                            rd_q        <= rd_address_in;
                            csr_addr_q  <= csr_address_in;
                            ld_q        <= load_in;
                            st_q        <= store_in & ~load_in;
                            sgn_q       <= load_signed_in;
                            size_q      <= load_store_size_in;
                            wdata_q     <= rs2_data_in;
                            exc_q       <= exception_in;
                            ecause_q    <= ecause_in;
                            valid_q     <= 1'b1;
                            if (!exception_in && misaligned) begin
                                exc_q    <= 1'b1;
                                ecause_q <= load_in ? 4'd4 : 4'd6;
                            end else if (!exception_in && is_mem) begin
                                valid_q <= 1'b0;
                                state_q <= ACCESS;
                            end
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    // stall/invalidate are ignored: a committed access always completes.
                    if (mem_ready) begin
                        state_q     <= IDLE;
                        valid_q     <= 1'b1;
                        load_data_q <= ld_q ? load_extract(size_q, alu_q[1:0], sgn_q, mem_load_data)
                                            : 32'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_out           = pc_q;
    assign next_pc_out      = next_pc_q;
    assign alu_data_out     = alu_q;
    assign csr_data_out     = csr_data_q;
    assign load_data_out    = load_data_q;
    assign branch_taken_out = branch_q;
    assign csr_write_out    = csr_write_q;
    assign mret_out         = mret_q;
    assign wfi_out          = wfi_q;
    assign valid_out        = valid_q;
    assign exception_out    = exc_q;
    assign write_select_out = wsel_q;
    assign rd_address_out   = rd_q;
    assign csr_address_out  = csr_addr_q;
    assign ecause_out       = ecause_q;

endmodule

// File: tb/tb_memory.sv
// Bench for the memory stage: directed scenarios plus randomized instructions,
// each compared against a behavioural model of the stage kept in this file.
module tb_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
    logic        branch_taken_in, load_in, store_in, load_signed_in, csr_write_in;
    logic        mret_in, wfi_in, valid_in, exception_in;
    logic [1:0]  load_store_size_in, write_select_in;
    logic [4:0]  rd_address_in;
    logic [11:0] csr_address_in;
    logic [3:0]  ecause_in;
    logic        stall, invalidate;
    logic [31:0] mem_address, mem_store_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_read, mem_write, mem_ready, mem_busy;
    logic [31:0] mem_load_data;
    logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
    logic        branch_taken_out, csr_write_out, mret_out, wfi_out, valid_out, exception_out;
    logic [1:0]  write_select_out;
    logic [4:0]  rd_address_out;
    logic [11:0] csr_address_out;
    logic [3:0]  ecause_out;

    int vectors = 0;
    int miscompares = 0;

    // Expected writeback-facing state
    logic [31:0] e_pc, e_npc, e_alu, e_csr, e_ld;
    logic        e_br, e_cw, e_mret, e_wfi, e_vld, e_exc;
    logic [1:0]  e_ws;
    logic [4:0]  e_rd;
    logic [11:0] e_ca;
    logic [3:0]  e_ec;

    memory dut (
        .clk(clk), .reset(reset),
        .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
        .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
        .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
        .load_signed_in(load_signed_in), .csr_write_in(csr_write_in), .mret_in(mret_in),
        .wfi_in(wfi_in), .valid_in(valid_in), .exception_in(exception_in),
        .load_store_size_in(load_store_size_in), .write_select_in(write_select_in),
        .rd_address_in(rd_address_in), .csr_address_in(csr_address_in), .ecause_in(ecause_in),
        .stall(stall), .invalidate(invalidate),
        .mem_address(mem_address), .mem_store_data(mem_store_data),
        .mem_byte_enable(mem_byte_enable), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ready(mem_ready), .mem_load_data(mem_load_data), .mem_busy(mem_busy),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
        .csr_data_out(csr_data_out), .load_data_out(load_data_out),
        .branch_taken_out(branch_taken_out), .csr_write_out(csr_write_out),
        .mret_out(mret_out), .wfi_out(wfi_out), .valid_out(valid_out),
        .exception_out(exception_out), .write_select_out(write_select_out),
        .rd_address_out(rd_address_out), .csr_address_out(csr_address_out),
        .ecause_out(ecause_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                             input logic [1:0] size, input logic sgn);
        longint unsigned u;
        longint v;
        u = 64'(w) >> (8 * (addr % 4));
        case (size)
            2'd0: begin v = longint'(u % 256);   if (sgn && v >= 128)   v = v - 256;   end
            2'd1: begin v = longint'(u % 65536); if (sgn && v >= 32768) v = v - 65536; end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic [1:0] size);
        int off;
        off = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << off);
        if (size == 2'd1) return 4'(3 << off);
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_sd(input logic [31:0] d, input logic [1:0] size);
        if (size == 2'd0) return (d % 256) * 32'h0101_0101;
        if (size == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    task automatic model_reset();
        {e_pc, e_npc, e_alu, e_csr, e_ld} = '0;
        {e_br, e_cw, e_mret, e_wfi, e_vld, e_exc} = '0;
        e_ws = '0; e_rd = '0; e_ca = '0; e_ec = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_valid"},  160'(valid_out),     160'(e_vld));
        chk({tag, "_exc"},    160'(exception_out), 160'(e_exc));
        chk({tag, "_ecause"}, 160'(ecause_out),    160'(e_ec));
        chk({tag, "_ldata"},  160'(load_data_out), 160'(e_ld));
        chk({tag, "_fields"},
            160'({pc_out, next_pc_out, alu_data_out, csr_data_out, branch_taken_out, csr_write_out,
                  mret_out, wfi_out, write_select_out, rd_address_out, csr_address_out}),
            160'({e_pc, e_npc, e_alu, e_csr, e_br, e_cw, e_mret, e_wfi, e_ws, e_rd, e_ca}));
    endtask

    task automatic check_idle_bus(input string tag);
        chk({tag, "_idle_rd"}, 160'(mem_read),        160'(0));
        chk({tag, "_idle_wr"}, 160'(mem_write),       160'(0));
        chk({tag, "_idle_be"}, 160'(mem_byte_enable), 160'(0));
        chk({tag, "_idle_bs"}, 160'(mem_busy),        160'(0));
    endtask

    // Presents one instruction (in IDLE, called just after a falling edge) and follows it to completion.
    task automatic step(input string tag, input logic v, input logic stl, input logic inv,
                        input logic ld, input logic st, input logic sgn, input logic exc,
                        input logic [1:0] size, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int delay);
        logic access, mis;
        access = 1'b0;
        valid_in = v; stall = stl; invalidate = inv;
        load_in = ld; store_in = st; load_signed_in = sgn; exception_in = exc;
        load_store_size_in = size; alu_data_in = addr; rs2_data_in = rs2;
        pc_in = $urandom; next_pc_in = $urandom; csr_data_in = $urandom;
        branch_taken_in = 1'($urandom); csr_write_in = 1'($urandom);
        mret_in = 1'($urandom); wfi_in = 1'($urandom);
        write_select_in = 2'($urandom); rd_address_in = 5'($urandom);
        csr_address_in = 12'($urandom); ecause_in = 4'($urandom);
        mem_ready = 1'b0; mem_load_data = $urandom;
        #1 check_idle_bus(tag);
        @(posedge clk);
        if (!stl) begin
            if (!v || inv) begin
                e_vld = 1'b0;
            end else begin
                e_pc = pc_in; e_npc = next_pc_in; e_alu = addr; e_csr = csr_data_in;
                e_br = branch_taken_in; e_cw = csr_write_in; e_mret = mret_in; e_wfi = wfi_in;
                e_ws = write_select_in; e_rd = rd_address_in; e_ca = csr_address_in;
                e_ld = 32'd0; e_exc = exc; e_ec = ecause_in; e_vld = 1'b1;
                mis = (ld || st) && ((size == 2'd1 && addr % 2 != 0) || (size >= 2'd2 && addr % 4 != 0));
                if (!exc && mis) begin
                    e_exc = 1'b1;
                    e_ec = ld ? 4'd4 : 4'd6;
                end else if (!exc && (ld || st)) begin
                    e_vld = 1'b0;
                    access = 1'b1;
                end
            end
        end
        @(negedge clk);
        check_regs({tag, "_acc"});
        if (access) begin
            for (int k = 0; k <= delay; k++) begin
                valid_in = 1'($urandom); stall = 1'($urandom); invalidate = 1'($urandom);
                exception_in = 1'($urandom); load_in = 1'($urandom); store_in = 1'($urandom);
                alu_data_in = $urandom; rs2_data_in = $urandom;
                load_store_size_in = 2'($urandom);
                mem_ready = (k == delay);
                mem_load_data = (k == delay) ? rdata : $urandom;
                #1;
                chk({tag, "_rd"},   160'(mem_read),        160'(ld));
                chk({tag, "_wr"},   160'(mem_write),       160'(st));
                chk({tag, "_addr"}, 160'(mem_address),     160'(addr - addr % 4));
                chk({tag, "_be"},   160'(mem_byte_enable), 160'(ref_be(addr, size)));
                chk({tag, "_busy"}, 160'(mem_busy),        160'(k != delay));
                if (st) chk({tag, "_sdata"}, 160'(mem_store_data), 160'(ref_sd(rs2, size)));
                @(posedge clk);
                if (k == delay) begin
                    e_vld = 1'b1;
                    e_ld = ld ? ref_load(rdata, addr, size, sgn) : 32'd0;
                end
                @(negedge clk);
                check_regs({tag, "_wait"});
            end
            mem_ready = 1'b0;
            valid_in = 1'b0; stall = 1'b0; invalidate = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b0; valid_in = 0; stall = 0; invalidate = 0; load_in = 0; store_in = 0;
        load_signed_in = 0; exception_in = 0; load_store_size_in = 0; alu_data_in = 0;
        rs2_data_in = 0; pc_in = 0; next_pc_in = 0; csr_data_in = 0; branch_taken_in = 0;
        csr_write_in = 0; mret_in = 0; wfi_in = 0; write_select_in = 0; rd_address_in = 0;
        csr_address_in = 0; ecause_in = 0; mem_ready = 0; mem_load_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_regs("reset");
        check_idle_bus("reset");
        reset = 1'b1;

        // lb signed from byte lane 3, ready on first access cycle
        step("lb103", 1, 0, 0, 1, 0, 1, 0, 2'd0, 32'h103, 32'h0, 32'h80FF_FF00, 0);
        chk("lb103_value", 160'(load_data_out), 160'(32'hFFFF_FF80));
        // sh to upper half with three wait cycles
        step("sh202", 1, 0, 0, 0, 1, 0, 0, 2'd1, 32'h202, 32'h1234_ABCD, 32'h0, 3);
        // misaligned lw / sw
        step("lw101", 1, 0, 0, 1, 0, 0, 0, 2'd2, 32'h101, 32'h0, 32'h0, 0);
        chk("lw101_cause", 160'(ecause_out), 160'(4));
        step("sw101", 1, 0, 0, 0, 1, 0, 0, 2'd2, 32'h101, 32'h0, 32'h0, 0);
        chk("sw101_cause", 160'(ecause_out), 160'(6));
        // exception from upstream suppresses the access
        step("excld", 1, 0, 0, 1, 0, 0, 1, 2'd2, 32'h100, 32'h0, 32'h0, 0);
        // ALU result then invalidated slot, then stall holding, then empty slot
        step("alu", 1, 0, 0, 0, 0, 0, 0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0);
        chk("alu_valid", 160'(valid_out), 160'(1));
        step("stall", 1, 1, 0, 0, 0, 0, 0, 2'd0, 32'h1111_2222, 32'h0, 32'h0, 0);
        step("inval", 1, 0, 1, 0, 0, 0, 0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 0);
        chk("inval_valid", 160'(valid_out), 160'(0));
        // size 3 behaves as word
        step("ld3", 1, 0, 0, 1, 0, 1, 0, 2'd3, 32'h40, 32'h0, 32'h8765_4321, 1);

        // reset in the middle of an access discards it
        valid_in = 1; load_in = 1; store_in = 0; exception_in = 0; load_store_size_in = 2'd2;
        alu_data_in = 32'h400; stall = 0; invalidate = 0; mem_ready = 0;
        @(posedge clk); @(negedge clk);
        chk("rst_mid_rd_before", 160'(mem_read), 160'(1));
        reset = 1'b0; valid_in = 0;
        @(posedge clk); @(negedge clk);
        model_reset();
        chk("rst_mid_rd", 160'(mem_read), 160'(0));
        chk("rst_mid_busy", 160'(mem_busy), 160'(0));
        check_regs("rst_mid");
        reset = 1'b1; mem_ready = 1'b1; mem_load_data = 32'hFFFF_FFFF;
        #1 chk("rst_late_busy", 160'(mem_busy), 160'(0));
        @(posedge clk); @(negedge clk);
        chk("rst_late_rd", 160'(mem_read), 160'(0));
        check_regs("rst_late");
        mem_ready = 1'b0;

        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(2);
            a = $urandom;
            if ($urandom_range(1) == 1) a[1:0] = 2'b00;
            step("rnd", 1'($urandom_range(9) != 0), 1'($urandom_range(7) == 0),
                 1'($urandom_range(9) == 0), 1'(kind == 1), 1'(kind == 2), 1'($urandom),
                 1'($urandom_range(7) == 0), 2'($urandom), a, $urandom, $urandom,
                 $urandom_range(3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
